// File: rtl/reg_dump_scanner_if.sv
// Debug dump bus: control inputs, register-file read port and output word stream.
interface reg_dump_scanner_if;
  logic        start;
  logic        single;
  logic [4:0]  sel_reg;
  logic        abort;
  logic [4:0]  regX;
  logic [31:0] Xdat;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, single, sel_reg, abort, Xdat, out_ready,
    output regX, out_data, out_idx, out_valid, busy, done
  );

  modport slave (
    output start, single, sel_reg, abort, Xdat, out_ready,
    input  regX, out_data, out_idx, out_valid, busy, done
  );
endinterface

// File: rtl/reg_dump_scanner.sv
// Walks the register file debug port and streams each value out over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start
// ADDR   | regX presented, Xdat captured at the closing edge
// SEND   | word offered on out_data/out_idx, waiting for out_ready
// DONE   | one-cycle done pulse after the last word
module reg_dump_scanner #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input logic PCclk,
  input logic rst_n,
  reg_dump_scanner_if.master bus
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_SEND, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx, last;
  logic [31:0] data_q;
  logic [4:0]  idx_q;
  logic        load, capture, advance;

  always_ff @(posedge PCclk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= 5'd0;
      last   <= 5'd0;
      data_q <= 32'd0;
      idx_q  <= 5'd0;
    end else begin
      state <= state_nxt;
      if (load) begin
        idx  <= bus.single ? bus.sel_reg : FIRST_IDX;
        last <= bus.single ? bus.sel_reg : LAST_IDX;
      end
      if (advance) idx <= idx + 5'd1;
      if (capture) begin
        data_q <= bus.Xdat;
        idx_q  <= idx;
      end
    end
  end

  // Abort outranks both start in IDLE and a same-cycle transfer in SEND.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          load      = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (bus.out_ready) begin
          if (idx == last) begin
            state_nxt = S_DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = S_ADDR;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.regX      = idx;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = (state == S_SEND);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Scoreboard bench for reg_dump_scanner: default sweep instance plus a 30..31 range instance.
module tb_reg_dump_scanner;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic        PCclk;
  logic        rst_n;
  logic [31:0] rf [32];
  int          cyc;
  int          n_checks;
  int          n_fail;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   xfer_a, xfer_b, done_a, done_b;
  int   done_cyc_a, done_cyc_b;
  int   prev_xfer;
  bit   gap_chk;
  bit   stall_prev;
  logic [31:0] stall_data;
  logic [4:0]  stall_idx;

  reg_dump_scanner_if bus_a ();
  reg_dump_scanner_if bus_b ();

  assign bus_a.Xdat = rf[bus_a.regX];
  assign bus_b.Xdat = rf[bus_b.regX];

  reg_dump_scanner dut_a (
    .PCclk (PCclk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  reg_dump_scanner #(.FIRST_REG(30), .LAST_REG(31)) dut_b (
    .PCclk (PCclk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial begin
    PCclk = 1'b0;
    forever #5 PCclk = ~PCclk;
  end

  always @(posedge PCclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Monitor for instance A: a transfer happens at the coming edge if valid & ready & !abort.
  always @(negedge PCclk) begin
    if (rst_n && bus_a.done) begin
      done_a++;
      done_cyc_a = cyc;
    end
    if (rst_n && bus_a.out_valid) begin
      if (stall_prev) begin
        n_checks++;
        if (bus_a.out_data !== stall_data || bus_a.out_idx !== stall_idx) begin
          n_fail++;
          $display("FAIL hold_stable: got idx %0d data %h expected idx %0d data %h",
                   bus_a.out_idx, bus_a.out_data, stall_idx, stall_data);
        end
      end
      if (bus_a.out_ready && !bus_a.abort) begin
        n_checks++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL xfer_a_unexpected: got idx %0d data %h expected no transfer",
                   bus_a.out_idx, bus_a.out_data);
        end else begin
          ea = q_a.pop_front();
          if (bus_a.out_idx !== ea.idx || bus_a.out_data !== ea.data) begin
            n_fail++;
            $display("FAIL xfer_a: got idx %0d data %h expected idx %0d data %h",
                     bus_a.out_idx, bus_a.out_data, ea.idx, ea.data);
          end
        end
        if (gap_chk && prev_xfer >= 0) begin
          n_checks++;
          if (cyc - prev_xfer != 2) begin
            n_fail++;
            $display("FAIL xfer_gap: got %0d cycles expected 2", cyc - prev_xfer);
          end
        end
        prev_xfer = cyc;
        xfer_a++;
      end
      stall_prev = !bus_a.out_ready && !bus_a.abort;
      stall_data = bus_a.out_data;
      stall_idx  = bus_a.out_idx;
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(negedge PCclk) begin
    if (rst_n && bus_b.done) begin
      done_b++;
      done_cyc_b = cyc;
    end
    if (rst_n && bus_b.out_valid && bus_b.out_ready && !bus_b.abort) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_b_unexpected: got idx %0d expected no transfer", bus_b.out_idx);
      end else begin
        eb = q_b.pop_front();
        if (bus_b.out_idx !== eb.idx || bus_b.out_data !== eb.data) begin
          n_fail++;
          $display("FAIL xfer_b: got idx %0d data %h expected idx %0d data %h",
                   bus_b.out_idx, bus_b.out_data, eb.idx, eb.data);
        end
      end
      xfer_b++;
    end
  end

  task automatic tick();
    @(posedge PCclk);
    #1;
  endtask

  task automatic wait_done(input bit on_b, input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((on_b ? done_b : done_a) > base) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.start = 1'b1;
    bus_b.start = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus_a.regX !== 5'd0 || bus_a.out_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_idx: got regX %0d out_idx %0d expected 0 0", bus_a.regX, bus_a.out_idx);
    end
    n_checks++;
    if (bus_a.out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", bus_a.out_data);
    end
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid %b busy %b done %b expected 0 0 0",
               bus_a.out_valid, bus_a.busy, bus_a.done);
    end
    rst_n = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    tick();
    n_checks++;
    if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: got busy %b %b expected 0 0", bus_a.busy, bus_b.busy);
    end
  endtask

  task automatic test_sweep();
    int  x0, d0, start_cyc;
    bit  ok;
    x0 = xfer_a;
    d0 = done_a;
    for (int i = 0; i < 32; i++) q_a.push_back({5'(i), rf[i]});
    prev_xfer = -1;
    gap_chk = 1'b1;
    bus_a.single = 1'b0;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    start_cyc = cyc;
    n_checks++;
    if (bus_a.busy !== 1'b1 || bus_a.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_addr: got busy %b valid %b expected 1 0", bus_a.busy, bus_a.out_valid);
    end
    tick();
    n_checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL sweep_latency: got valid %b idx %0d expected 1 0", bus_a.out_valid, bus_a.out_idx);
    end
    wait_done(1'b0, d0, 200, ok);
    gap_chk = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sweep_timeout: got no done expected done within 200 cycles");
    end
    n_checks++;
    if (xfer_a - x0 !== 32 || done_a - d0 !== 1) begin
      n_fail++;
      $display("FAIL sweep_counts: got xfers %0d dones %0d expected 32 1", xfer_a - x0, done_a - d0);
    end
    n_checks++;
    if (done_cyc_a - start_cyc !== 64) begin
      n_fail++;
      $display("FAIL sweep_timing: got %0d cycles expected 64", done_cyc_a - start_cyc);
    end
    n_checks++;
    if (bus_a.busy !== 1'b0 || q_a.size() !== 0) begin
      n_fail++;
      $display("FAIL sweep_end: got busy %b pending %0d expected 0 0", bus_a.busy, q_a.size());
    end
  endtask

  task automatic test_single();
    int x0, d0;
    bit ok;
    x0 = xfer_a;
    d0 = done_a;
    rf[7] = 32'hDEADBEEF;
    q_a.push_back({5'd7, 32'hDEADBEEF});
    bus_a.single = 1'b1;
    bus_a.sel_reg = 5'd7;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_a.single = 1'b0;
    bus_a.sel_reg = 5'd0;
    wait_done(1'b0, d0, 20, ok);
    n_checks++;
    if (!ok || xfer_a - x0 !== 1 || done_a - d0 !== 1) begin
      n_fail++;
      $display("FAIL single: got ok %b xfers %0d dones %0d expected 1 1 1", ok, xfer_a - x0, done_a - d0);
    end
    n_checks++;
    if (q_a.size() !== 0 || bus_a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: got pending %0d busy %b expected 0 0", q_a.size(), bus_a.busy);
    end
    rf[7] = 32'd7;
  endtask

  task automatic test_stall();
    int x0, d0, n;
    bit ok, hit;
    x0 = xfer_a;
    d0 = done_a;
    hit = 1'b0;
    for (int i = 0; i < 32; i++) q_a.push_back({5'(i), rf[i]});
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_a.out_valid && bus_a.out_idx == 5'd3) begin
        hit = 1'b1;
        break;
      end
    end
    bus_a.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) rf[3] = 32'hBAD00003;
      n_checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_idx !== 5'd3 || bus_a.out_data !== 32'd3 ||
          bus_a.regX !== 5'd3) begin
        n_fail++;
        $display("FAIL stall_hold: got valid %b idx %0d data %h regX %0d expected 1 3 3 3",
                 bus_a.out_valid, bus_a.out_idx, bus_a.out_data, bus_a.regX);
      end
    end
    bus_a.out_ready = 1'b1;
    n = xfer_a;
    tick();
    rf[3] = 32'd3;
    n_checks++;
    if (!hit || xfer_a !== n + 1 || bus_a.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got hit %b xfers %0d valid %b expected 1 %0d 0",
               hit, xfer_a, bus_a.out_valid, n + 1);
    end
    wait_done(1'b0, d0, 200, ok);
    n_checks++;
    if (!ok || xfer_a - x0 !== 32 || done_a - d0 !== 1 || q_a.size() !== 0) begin
      n_fail++;
      $display("FAIL stall_counts: got ok %b xfers %0d dones %0d pending %0d expected 1 32 1 0",
               ok, xfer_a - x0, done_a - d0, q_a.size());
    end
  endtask

  task automatic test_abort();
    int  x0, d0;
    bit  hit;
    x0 = xfer_a;
    d0 = done_a;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) q_a.push_back({5'(i), rf[i]});
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_a.out_valid && bus_a.out_idx == 5'd10) begin
        hit = 1'b1;
        break;
      end
    end
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    n_checks++;
    if (!hit || bus_a.busy !== 1'b0 || bus_a.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got hit %b busy %b valid %b expected 1 0 0", hit, bus_a.busy, bus_a.out_valid);
    end
    repeat (4) tick();
    n_checks++;
    if (xfer_a - x0 !== 10 || done_a !== d0 || q_a.size() !== 0) begin
      n_fail++;
      $display("FAIL abort_counts: got xfers %0d dones %0d pending %0d expected 10 0 0",
               xfer_a - x0, done_a - d0, q_a.size());
    end
    q_a.push_back({5'd0, rf[0]});
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    tick();
    n_checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL abort_restart: got valid %b idx %0d expected 1 0", bus_a.out_valid, bus_a.out_idx);
    end
    tick();
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    n_checks++;
    if (bus_a.busy !== 1'b0 || done_a !== d0 || q_a.size() !== 0) begin
      n_fail++;
      $display("FAIL abort_in_addr: got busy %b dones %0d pending %0d expected 0 0 0",
               bus_a.busy, done_a - d0, q_a.size());
    end
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    n_checks++;
    if (bus_a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_beats_start: got busy %b expected 0", bus_a.busy);
    end
  endtask

  task automatic test_reset_mid();
    int x0, d0;
    bit hit, poked;
    x0 = xfer_a;
    d0 = done_a;
    hit = 1'b0;
    poked = 1'b0;
    for (int i = 0; i < 20; i++) q_a.push_back({5'(i), rf[i]});
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      bus_a.start = 1'b0;
      if (bus_a.out_valid && bus_a.out_idx == 5'd5 && !poked) begin
        bus_a.start = 1'b1;
        poked = 1'b1;
      end
      if (bus_a.out_valid && bus_a.out_idx == 5'd20) begin
        hit = 1'b1;
        break;
      end
    end
    bus_a.start = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (!hit || bus_a.regX !== 5'd0 || bus_a.out_idx !== 5'd0 || bus_a.out_data !== 32'd0 ||
        bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got hit %b regX %0d idx %0d data %h valid %b busy %b done %b expected 1 0 0 0 0 0 0",
               hit, bus_a.regX, bus_a.out_idx, bus_a.out_data, bus_a.out_valid, bus_a.busy, bus_a.done);
    end
    repeat (4) tick();
    n_checks++;
    if (xfer_a - x0 !== 20 || done_a !== d0 || q_a.size() !== 0 || bus_a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_counts: got xfers %0d dones %0d pending %0d busy %b expected 20 0 0 0",
               xfer_a - x0, done_a - d0, q_a.size(), bus_a.busy);
    end
  endtask

  task automatic test_short_range();
    int d0, start_cyc;
    bit ok;
    d0 = done_b;
    q_b.push_back({5'd30, rf[30]});
    q_b.push_back({5'd31, rf[31]});
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    start_cyc = cyc;
    wait_done(1'b1, d0, 20, ok);
    n_checks++;
    if (!ok || xfer_b !== 2 || done_b - d0 !== 1 || q_b.size() !== 0) begin
      n_fail++;
      $display("FAIL range_counts: got ok %b xfers %0d dones %0d pending %0d expected 1 2 1 0",
               ok, xfer_b, done_b - d0, q_b.size());
    end
    n_checks++;
    if (done_cyc_b - start_cyc !== 4) begin
      n_fail++;
      $display("FAIL range_timing: got %0d cycles expected 4", done_cyc_b - start_cyc);
    end
    repeat (3) tick();
    n_checks++;
    if (bus_b.regX !== 5'd31 || bus_b.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL range_no_wrap: got regX %0d busy %b expected 31 0", bus_b.regX, bus_b.busy);
    end
  endtask

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    xfer_a = 0;
    xfer_b = 0;
    done_a = 0;
    done_b = 0;
    done_cyc_a = 0;
    done_cyc_b = 0;
    prev_xfer = -1;
    gap_chk = 1'b0;
    stall_prev = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    rst_n = 1'b0;
    bus_a.start = 1'b0;
    bus_a.single = 1'b0;
    bus_a.sel_reg = 5'd0;
    bus_a.abort = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.start = 1'b0;
    bus_b.single = 1'b0;
    bus_b.sel_reg = 5'd0;
    bus_b.abort = 1'b0;
    bus_b.out_ready = 1'b1;

    test_reset();
    test_sweep();
    test_single();
    test_stall();
    test_abort();
    test_reset_mid();
    test_short_range();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump_scanner.md
REG_DUMP_SCANNER -- requirements
Module: reg_dump_scanner

Interface
REQ-001 Parameter FIRST_REG, default 0: first register index of a full sweep.
REQ-002 Parameter LAST_REG, default 31: last register index of a full sweep; FIRST_REG <= LAST_REG <= 31 is a legal-configuration requirement.
REQ-003 PCclk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a dump; sampled only in IDLE.
REQ-006 single  input  1  1 = dump only sel_reg, 0 = sweep FIRST_REG..LAST_REG; sampled with start.
REQ-007 sel_reg  input  5  register index for single mode; sampled with start.
REQ-008 abort  input  1  cancel the dump in progress.
REQ-009 regX  output  5  register-file debug read address.
REQ-010 Xdat  input  32  register-file debug read data, combinational from regX.
REQ-011 out_data  output  32  captured register value.
REQ-012 out_idx  output  5  index of the register in out_data.
REQ-013 out_valid  output  1  out_data/out_idx valid.
REQ-014 out_ready  input  1  sink accepts the word.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 FSM states: IDLE, ADDR, SEND, DONE; encoding is free.
REQ-018 IDLE: at a rising edge with start=1, load idx = (single ? sel_reg : FIRST_REG), latch last = (single ? sel_reg : LAST_REG), go to ADDR; otherwise stay in IDLE.
REQ-019 regX SHALL equal idx in every state and hold stable through ADDR and SEND.
REQ-020 ADDR: lasts exactly one cycle; at its closing edge capture Xdat into out_data, idx into out_idx, go to SEND.
REQ-021 Latency: start sampled at edge k -> out_valid=1 after edge k+1.
REQ-022 SEND: out_valid=1; out_data and out_idx SHALL NOT change while out_valid=1 and out_ready=0.
REQ-023 Transfer occurs at an edge with out_valid=1 and out_ready=1; out_valid drops after that edge.
REQ-024 After a transfer with idx != last: idx <= idx+1, go to ADDR (next out_valid two cycles after the previous transfer edge).
REQ-025 After a transfer with idx == last: go to DONE; idx does not increment and never wraps past 31.
REQ-026 DONE: done=1 for exactly that cycle, then IDLE; busy=1 in DONE.
REQ-027 start while busy=1 is ignored; no queuing.
REQ-028 abort=1 in any non-IDLE state: next state IDLE, out_valid=0, no done pulse; abort takes priority over a simultaneous transfer; abort in IDLE has no effect, and abort wins over start in IDLE.
REQ-029 Xdat is captured only at the ADDR edge; register-file writes after capture do not alter out_data.
REQ-030 Full sweep with default parameters produces exactly 32 transfers, out_idx 0..31 in ascending order.

Reset
REQ-031 rst_n=0 at a rising edge: state IDLE, idx=0, regX=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0.
REQ-032 Reset mid-dump has the same effect as REQ-031, with no done pulse and no further transfers.
REQ-033 start asserted while rst_n=0 is ignored.

Verification
REQ-034 Register file preloaded reg[i]=i, out_ready=1, single=0, start pulse -> out_valid after 2 edges; 32 transfers with out_data=out_idx=0..31 two cycles apart; done pulses once; busy falls.
REQ-035 single=1, sel_reg=7, reg[7]=0xDEADBEEF -> one transfer with out_idx=7 and out_data=0xDEADBEEF, then done.
REQ-036 out_ready held 0 for 5 cycles during the word for reg 3 -> out_valid, out_data=3, and out_idx=3 held constant; regX=3 throughout; transfer on the first ready edge.
REQ-037 abort asserted during SEND of reg 10 with out_ready=1 -> no transfer counted, IDLE next cycle, done never pulses; a new start then begins at reg 0.
REQ-038 rst_n=0 for one edge during the sweep at reg 20 -> all outputs 0 per REQ-031; a start pulse during a busy dump has no effect.
REQ-039 FIRST_REG=30, LAST_REG=31 -> exactly two transfers (30, 31); idx stays at 31, no wrap to 0.
